// File: rtl/sprite_motion_engine.sv
// Wishbone-mapped game-object state: ship position, one ship bullet, three aliens.
// Moves the bullet once per frame tick, resolves alien hits, keeps score and raises a hit irq.
module sprite_motion_engine #(
    parameter int H_RES        = 640,
    parameter int SHIP_W       = 20,
    parameter int SHIP_Y       = 380,
    parameter int BULLET_W     = 2,
    parameter int BULLET_H     = 5,
    parameter int BULLET_SPEED = 4,
    parameter int ALIEN_Y      = 240,
    parameter int ALIEN0_X     = 320,
    parameter int ALIEN1_X     = 350,
    parameter int ALIEN2_X     = 290,
    parameter int PARK_Y       = 1023
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        frame_tick_i,
    output logic [9:0]  ship_x_o,
    output logic [9:0]  ship_bullet_x_o,
    output logic [9:0]  ship_bullet_y_o,
    output logic [15:0] sprite_display_o,
    output logic        hit_irq_o
);

    typedef enum logic [1:0] {IDLE, MOVE, CHECK, HIT} state_t;

    localparam logic [9:0]  SHIP_X_MAX = 10'(H_RES - SHIP_W);
    localparam logic [9:0]  FIRE_Y     = 10'(SHIP_Y - BULLET_H);
    localparam logic [9:0]  SPEED      = 10'(BULLET_SPEED);
    localparam logic [9:0]  PARK       = 10'(PARK_Y);
    localparam logic [10:0] AY         = 11'(ALIEN_Y);

    state_t      state, state_nxt;
    logic [9:0]  ship_x, bullet_x, bullet_y;
    logic [15:0] alive, score;
    logic [2:0]  hit_flags, hit_sel, hit_vec, hit_lo;
    logic [1:0]  reg_sel;
    logic        req, wr, fire_req;
    logic [31:0] rd_data, ship_x_m, alive_m;
    logic [15:0] alive_nxt;
    logic        unused_adr;

    assign unused_adr = ^{wb_adr_i[31:4], wb_adr_i[1:0]};

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [10:0] alien_x(input int idx);
        case (idx)
            0:       return 11'(ALIEN0_X);
            1:       return 11'(ALIEN1_X);
            default: return 11'(ALIEN2_X);
        endcase
    endfunction

    assign req      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr       = req & wb_we_i;
    assign reg_sel  = wb_adr_i[3:2];
    assign fire_req = wr && reg_sel == 2'd2 && wb_sel_i[0] && wb_dat_i[0];
    assign ship_x_m = merge({22'b0, ship_x}, wb_dat_i, wb_sel_i);
    assign alive_m  = merge({16'b0, alive}, wb_dat_i, wb_sel_i);

    // 11-bit overlap test so bx+BULLET_W / by+BULLET_H cannot wrap near 1023
    always_comb begin
        logic [10:0] bx, by, ax;
        hit_vec = '0;
        bx = {1'b0, bullet_x};
        by = {1'b0, bullet_y};
        for (int i = 0; i < 3; i++) begin
            ax = alien_x(i);
            hit_vec[i] = alive[i] && (bx < ax + 11'(SHIP_W)) && (ax < bx + 11'(BULLET_W)) &&
                         (by < AY + 11'(SHIP_W)) && (AY < by + 11'(BULLET_H));
        end
    end

    assign hit_lo = hit_vec & (~hit_vec + 3'd1);

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            2'd0: rd_data = {22'b0, ship_x};
            2'd1: rd_data = {16'b0, alive};
            2'd2: rd_data = {6'b0, bullet_y, 15'b0, state != IDLE};
            2'd3: rd_data = {score, 13'b0, hit_flags};
        endcase
    end

    // ALIVE write lands first; a kill in the same cycle still clears its bit
    always_comb begin
        alive_nxt = alive;
        if (wr && reg_sel == 2'd1) alive_nxt = alive_m[15:0];
        if (state == HIT) alive_nxt = alive_nxt & ~{13'b0, hit_sel};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (fire_req) state_nxt = MOVE;
            MOVE:  if (frame_tick_i) state_nxt = (bullet_y < SPEED) ? IDLE : CHECK;
            CHECK: state_nxt = (|hit_vec) ? HIT : MOVE;
            HIT:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ship_x    <= 10'd310;
            bullet_x  <= '0;
            bullet_y  <= PARK;
            alive     <= 16'h0007;
            score     <= '0;
            hit_flags <= '0;
            hit_sel   <= '0;
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= '0;
            hit_irq_o <= 1'b0;
        end else begin
            wb_ack_o  <= req;
            wb_dat_o  <= req ? rd_data : 32'h0;
            hit_irq_o <= (state == HIT);
            alive     <= alive_nxt;
            if (state == CHECK) hit_sel <= hit_lo;

            if (wr && reg_sel == 2'd0)
                ship_x <= (ship_x_m > {22'b0, SHIP_X_MAX}) ? SHIP_X_MAX : ship_x_m[9:0];

            if (wr && reg_sel == 2'd3 && wb_sel_i[0])
                hit_flags <= (hit_flags & ~wb_dat_i[2:0]) | ((state == HIT) ? hit_sel : 3'b0);
            else if (state == HIT)
                hit_flags <= hit_flags | hit_sel;

            if (state == HIT)
                score <= (score == 16'hFFFF) ? score : score + 16'd1;
            else if (wr && reg_sel == 2'd3 && wb_sel_i[3] && wb_dat_i[31])
                score <= '0;

            case (state)
                IDLE: if (fire_req) begin
                    bullet_x <= ship_x + 10'd9;
                    bullet_y <= FIRE_Y;
                end
                MOVE: if (frame_tick_i)
                    bullet_y <= (bullet_y < SPEED) ? PARK : bullet_y - SPEED;
                HIT:  bullet_y <= PARK;
                default: ;
            endcase
        end
    end

    assign ship_x_o         = ship_x;
    assign ship_bullet_x_o  = bullet_x;
    assign ship_bullet_y_o  = bullet_y;
    assign sprite_display_o = alive;

endmodule

// File: tb/tb_sprite_motion_engine.sv
// Directed bench for sprite_motion_engine: bus access, flight, collision, park, reset, saturation.
module tb_sprite_motion_engine;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        frame_tick_i = 1'b0;
    logic [9:0]  ship_x_o, ship_bullet_x_o, ship_bullet_y_o;
    logic [15:0] sprite_display_o;
    logic        hit_irq_o;

    int n_tests = 0, n_fail = 0;
    int irq_cnt = 0, ack_dbl = 0;
    logic ack_prev = 1'b0;

    sprite_motion_engine dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .frame_tick_i(frame_tick_i),
        .ship_x_o(ship_x_o), .ship_bullet_x_o(ship_bullet_x_o), .ship_bullet_y_o(ship_bullet_y_o),
        .sprite_display_o(sprite_display_o), .hit_irq_o(hit_irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    always @(posedge wb_clk_i) begin
        if (hit_irq_o) irq_cnt++;
        if (wb_ack_o && ack_prev) ack_dbl++;
        ack_prev = wb_ack_o;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdat);
        int n;
        @(negedge wb_clk_i);
        wb_adr_i = adr; wb_we_i = we; wb_dat_i = dat; wb_sel_i = sel;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        n = 0;
        do begin
            @(posedge wb_clk_i); #1; n++;
        end while (!wb_ack_o && n < 10);
        if (!wb_ack_o) check("ack_timeout", 32'd0, 32'd1);
        rdat = wb_dat_o;
        @(negedge wb_clk_i);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic [31:0] d;
        wb_xfer(adr, 1'b1, dat, sel, d);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        wb_xfer(adr, 1'b0, 32'h0, 4'hF, d);
        check(tag, d, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge wb_clk_i); frame_tick_i = 1'b1;
            @(negedge wb_clk_i); frame_tick_i = 1'b0;
            repeat (3) @(negedge wb_clk_i);
        end
    endtask

    initial begin
        int irq0;
        repeat (3) @(negedge wb_clk_i);
        check("rst_bullet_y_during_reset", 32'(ship_bullet_y_o), 32'd1023);
        wb_rst_i = 1'b0;

        // reset state
        rd_check("rst_ship_x", 32'h0, 32'd310);
        rd_check("rst_alive",  32'h4, 32'h0000_0007);
        rd_check("rst_fire",   32'h8, 32'h03FF_0000);
        rd_check("rst_hit",    32'hC, 32'h0000_0000);
        check("rst_bullet_y", 32'(ship_bullet_y_o), 32'd1023);

        // ship_x clamp and byte lanes
        wr(32'h0, 32'd700, 4'hF);
        rd_check("ship_x_clamp", 32'h0, 32'd620);
        wr(32'h0, 32'h155, 4'b0001);
        rd_check("ship_x_sel0", 32'h0, 32'h255);
        wr(32'h0, 32'd620, 4'hF);
        rd_check("ship_x_620", 32'h0, 32'd620);

        // alien0 kill
        irq0 = irq_cnt;
        wr(32'h0, 32'd311, 4'hF);
        wr(32'h8, 32'h1, 4'hF);
        check("fire_x", 32'(ship_bullet_x_o), 32'd320);
        check("fire_y", 32'(ship_bullet_y_o), 32'd375);
        tick(34);
        rd_check("kill_alive", 32'h4, 32'h0000_0006);
        rd_check("kill_hit",   32'hC, 32'h0001_0001);
        check("kill_irq_cnt", 32'(irq_cnt - irq0), 32'd1);
        check("kill_bullet_y", 32'(ship_bullet_y_o), 32'd1023);
        check("kill_display", 32'(sprite_display_o), 32'h0006);

        // W1C flags and score clear
        wr(32'hC, 32'h8000_0001, 4'b1001);
        rd_check("hit_clear", 32'hC, 32'h0);

        // long flight with no aliens
        irq0 = irq_cnt;
        wr(32'h4, 32'h0, 4'hF);
        wr(32'h0, 32'h0, 4'hF);
        wr(32'h8, 32'h1, 4'hF);
        tick(93);
        rd_check("flight_y3", 32'h8, 32'h0003_0001);
        tick(1);
        rd_check("flight_parked", 32'h8, 32'h03FF_0000);
        check("flight_irq_cnt", 32'(irq_cnt - irq0), 32'd0);
        rd_check("flight_score", 32'hC, 32'h0);

        // double fire, then re-fire after park
        wr(32'h8, 32'h1, 4'hF);
        tick(1);
        wr(32'h8, 32'h1, 4'hF);
        rd_check("refire_ignored", 32'h8, 32'h0173_0001);
        for (int i = 0; i < 100; i++) begin
            if (ship_bullet_y_o == 10'd1023) break;
            tick(1);
        end
        check("refire_parked", 32'(ship_bullet_y_o), 32'd1023);
        wr(32'h8, 32'h1, 4'hF);
        check("refire_new_y", 32'(ship_bullet_y_o), 32'd375);
        check("refire_new_x", 32'(ship_bullet_x_o), 32'd9);

        // reset mid-flight
        wr(32'h0, 32'd100, 4'hF);
        tick(3);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        #1;
        check("rst_mid_ship_x",  32'(ship_x_o), 32'd310);
        check("rst_mid_bul_y",   32'(ship_bullet_y_o), 32'd1023);
        check("rst_mid_bul_x",   32'(ship_bullet_x_o), 32'd0);
        check("rst_mid_display", 32'(sprite_display_o), 32'h0007);
        check("rst_mid_irq",     32'(hit_irq_o), 32'd0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        rd_check("rst_mid_fire", 32'h8, 32'h03FF_0000);

        // score saturation: ship at 310 -> bullet x 319 overlaps alien0
        @(negedge wb_clk_i);
        force dut.score = 16'hFFFF;
        @(negedge wb_clk_i);
        release dut.score;
        wr(32'h8, 32'h1, 4'hF);
        tick(32);
        rd_check("sat_hit",   32'hC, 32'hFFFF_0001);
        rd_check("sat_alive", 32'h4, 32'h0000_0006);

        check("ack_never_double", 32'(ack_dbl), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
